fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of instruction_mem. Owns the program
//   counter, drives pc into instruction_mem and takes back its combinational decoded
//   fields (opcode/rd/rs/imm/address) in the same cycle. Registers them into an IF/ID
//   pipeline register with valid/ready handshake to decode. Handles sequential
//   fetch, jumps decoded locally, branch redirect from execute, stall, halt, start.
// PARAMETERS
//   PC_W         8       program counter width (instruction_mem address width)
//   RESET_PC     8'h00   pc value after reset and after restart from HALTED
//   JMP_OPCODE   3'b111  opcode treated as unconditional jump to {0, address}
//   HALT_OPCODE  3'b110  opcode that stops fetching
// PORTS
//   clk          in   1     clock, all state updates on rising edge
//   rst          in   1     synchronous, active-high reset
//   start        in   1     leave IDLE/HALTED and begin fetching at RESET_PC
//   pc           out  PC_W  fetch address to instruction_mem (= pc_q)
//   imem_opcode  in   3     opcode from instruction_mem for current pc
//   imem_rd      in   1     rd field from instruction_mem
//   imem_rs      in   1     rs field from instruction_mem
//   imem_imm     in   3     imm field from instruction_mem
//   imem_addr    in   5     address field from instruction_mem
//   br_taken     in   1     execute-stage redirect request (one-cycle pulse)
//   br_target    in   PC_W  redirect target, valid when br_taken=1
//   id_valid     out  1     IF/ID register holds an instruction
//   id_ready     in   1     decode accepts IF/ID contents this cycle
//   id_opcode    out  3     registered opcode
//   id_rd        out  1     registered rd
//   id_rs        out  1     registered rs
//   id_imm       out  3     registered imm
//   id_addr      out  5     registered address
//   id_pc        out  PC_W  pc the registered instruction was fetched from
//   halted       out  1     high in HALTED state
// BEHAVIOUR
//   Reset: state=IDLE, pc_q=RESET_PC, id_valid=0, id_* fields=0, id_pc=0, halted=0.
//   States: IDLE -(start)-> RUN; RUN -(HALT fetched)-> HALTED; HALTED -(start)-> RUN.
//   IDLE: no fetch, pc_q holds RESET_PC; br_taken ignored.
//   advance = !id_valid | id_ready (IF/ID slot free or being emptied).
//   RUN, per edge, priority high to low:
//    1 br_taken: pc_q<=br_target; id_valid<=0 (flush, regardless of id_ready).
//    2 advance: capture imem_* into id_*, id_pc<=pc_q, id_valid<=1, then
//      opcode==JMP_OPCODE : pc_q<={0,imem_addr} (zero-extended);
//      opcode==HALT_OPCODE: pc_q holds, state<=HALTED, halted<=1 next cycle;
//      otherwise          : pc_q<=pc_q+1, wraps 2^PC_W-1 -> 0.
//    3 else (stall): pc_q and all id_* hold.
//   JMP and HALT instructions are themselves passed to decode with id_valid=1.
//   Latency: instruction at pc_q appears on id_* one edge after fetch; first id_valid
//     is the second edge after start sampled high (IDLE->RUN, then fetch RESET_PC).
//   HALTED: no fetch; id_valid clears when id_ready=1; br_taken ignored;
//     start -> pc_q<=RESET_PC, halted<=0, state RUN, IF/ID content left to drain.
//   br_taken same cycle as HALT fetch: redirect wins, HALT not captured, stay RUN.
//   start while RUN: ignored. rst any cycle overrides all, returns to reset values.
//   id_* must not change while id_valid=1 and id_ready=0 unless br_taken flushes.
// TESTING
//   1 rst, start=1 one cycle, id_ready=1, sequential non-jump program -> pc 0,1,2,3;
//     id_pc 0,1,2 one edge behind; id_valid rises second edge after start.
//   2 id_ready=0 for 3 cycles with id_valid=1 at pc=5 -> pc=5, id_pc=4 frozen;
//     id_ready=1 -> pc=6, id_pc=5 next edge.
//   3 JMP_OPCODE at pc=2, imem_addr=5'd20 -> next pc=20, id_pc=2 with opcode 3'b111,
//     following id_pc=20.
//   4 br_taken=1, br_target=8'h40 while id_valid=1, id_ready=0 -> next edge id_valid=0,
//     pc=8'h40; simultaneous HALT fetch not captured, halted stays 0.
//   5 HALT_OPCODE at pc=3 -> halted=1, pc stays 3, id_pc=3 drains; start -> pc=0, RUN.
//   6 pc=8'hFF non-jump -> pc=8'h00; rst asserted mid-RUN -> pc=0, id_valid=0, IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from a combinational instruction
// memory and hands decoded fields to decode through a valid/ready IF/ID register.
module fetch_unit #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [2:0]      JMP_OPCODE  = 3'b111,
  parameter logic [2:0]      HALT_OPCODE = 3'b110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [2:0]      imem_opcode,
  input  logic            imem_rd,
  input  logic            imem_rs,
  input  logic [2:0]      imem_imm,
  input  logic [4:0]      imem_addr,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [2:0]      id_opcode,
  output logic            id_rd,
  output logic            id_rs,
  output logic [2:0]      id_imm,
  output logic [4:0]      id_addr,
  output logic [PC_W-1:0] id_pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_id_valid;
  logic [2:0]      r_id_opcode;
  logic            r_id_rd;
  logic            r_id_rs;
  logic [2:0]      r_id_imm;
  logic [4:0]      r_id_addr;
  logic [PC_W-1:0] r_id_pc;
  logic            r_halted;

  logic            w_advance;
  logic [PC_W-1:0] w_jmp_target;
  logic [PC_W-1:0] w_seq_pc;

  // The IF/ID slot can take a new instruction when empty or being drained this cycle.
  assign w_advance    = !r_id_valid || id_ready;
  assign w_jmp_target = PC_W'(imem_addr);
  assign w_seq_pc     = r_pc + PC_W'(1);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_id_opcode <= '0;
      r_id_rd     <= 1'b0;
      r_id_rs     <= 1'b0;
      r_id_imm    <= '0;
      r_id_addr   <= '0;
      r_id_pc     <= '0;
      r_halted    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
          end
        end

        S_RUN: begin
          if (br_taken) begin
            r_pc       <= br_target;
            r_id_valid <= 1'b0;
          end else if (w_advance) begin
            r_id_valid  <= 1'b1;
            r_id_opcode <= imem_opcode;
            r_id_rd     <= imem_rd;
            r_id_rs     <= imem_rs;
            r_id_imm    <= imem_imm;
            r_id_addr   <= imem_addr;
            r_id_pc     <= r_pc;
            if (imem_opcode == JMP_OPCODE) begin
              r_pc <= w_jmp_target;
            end else if (imem_opcode == HALT_OPCODE) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_seq_pc;
            end
          end
        end

        S_HALTED: begin
          // The last instruction (the HALT itself) still drains to decode.
          if (id_ready) begin
            r_id_valid <= 1'b0;
          end
          if (start) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc        = r_pc;
  assign id_valid  = r_id_valid;
  assign id_opcode = r_id_opcode;
  assign id_rd     = r_id_rd;
  assign id_rs     = r_id_rs;
  assign id_imm    = r_id_imm;
  assign id_addr   = r_id_addr;
  assign id_pc     = r_id_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bench-owned instruction memory answers pc,
// per-cycle vector tables carry stimulus plus hand-derived post-edge expectations.
module tb_fetch_unit;

  typedef struct packed {
    logic [2:0] op;
    logic       rd;
    logic       rs;
    logic [2:0] imm;
    logic [4:0] addr;
  } instr_t;

  typedef struct {
    logic       rst;
    logic       start;
    logic       br;
    logic [7:0] tgt;
    logic       rdy;
    logic [7:0] e_pc;
    logic       e_v;
    logic [7:0] e_idpc;
    logic       e_h;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, br_taken, id_ready;
  logic [7:0] br_target, pc, id_pc;
  logic [2:0] imem_opcode, id_opcode, imem_imm, id_imm;
  logic       imem_rd, imem_rs, id_rd, id_rs, id_valid, halted;
  logic [4:0] imem_addr, id_addr;

  instr_t mem [256];
  vec_t   tbl [$];
  vec_t   exp_q [$];
  int     n_vec = 0;
  int     n_err = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .imem_opcode(imem_opcode),
    .imem_rd    (imem_rd),
    .imem_rs    (imem_rs),
    .imem_imm   (imem_imm),
    .imem_addr  (imem_addr),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_opcode  (id_opcode),
    .id_rd      (id_rd),
    .id_rs      (id_rs),
    .id_imm     (id_imm),
    .id_addr    (id_addr),
    .id_pc      (id_pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign {imem_opcode, imem_rd, imem_rs, imem_imm, imem_addr} = mem[pc];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Default program: no jumps or halts, fields derived from the address.
  task automatic reset_mem();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      mem[i] = '{op: 3'd0, rd: b[0], rs: b[1], imm: b[2:0], addr: b[4:0]};
    end
  endtask

  task automatic add(input logic r, input logic s, input logic b, input logic [7:0] t,
                     input logic y, input logic [7:0] epc, input logic ev,
                     input logic [7:0] eidpc, input logic eh);
    tbl.push_back('{rst: r, start: s, br: b, tgt: t, rdy: y,
                    e_pc: epc, e_v: ev, e_idpc: eidpc, e_h: eh});
  endtask

  task automatic run_tbl();
    vec_t v, e;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst       = v.rst;
      start     = v.start;
      br_taken  = v.br;
      br_target = v.tgt;
      id_ready  = v.rdy;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("pc", 32'(pc), 32'(e.e_pc));
      check("id_valid", 32'(id_valid), 32'(e.e_v));
      check("halted", 32'(halted), 32'(e.e_h));
      if (e.e_v) begin
        check("id_pc", 32'(id_pc), 32'(e.e_idpc));
        check("id_fields", 32'({id_opcode, id_rd, id_rs, id_imm, id_addr}), 32'(mem[e.e_idpc]));
      end
    end
    tbl.delete();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; br_taken = 1'b0;
  endtask

  task automatic check_reset_fields();
    check("rst_id_pc", 32'(id_pc), 32'd0);
    check("rst_id_fields", 32'({id_opcode, id_rd, id_rs, id_imm, id_addr}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; br_taken = 1'b0; br_target = '0; id_ready = 1'b1;
    reset_mem();

    // Sequential fetch, start latency, stall, start ignored while running.
    add(1, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 1, 8'h40, 1,  8'h00, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h01, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h02, 1, 8'h01, 0);
    add(0, 0, 0, 8'h00, 1,  8'h03, 1, 8'h02, 0);
    add(0, 0, 0, 8'h00, 1,  8'h04, 1, 8'h03, 0);
    add(0, 0, 0, 8'h00, 1,  8'h05, 1, 8'h04, 0);
    add(0, 0, 0, 8'h00, 0,  8'h05, 1, 8'h04, 0);
    add(0, 0, 0, 8'h00, 0,  8'h05, 1, 8'h04, 0);
    add(0, 0, 0, 8'h00, 0,  8'h05, 1, 8'h04, 0);
    add(0, 0, 0, 8'h00, 1,  8'h06, 1, 8'h05, 0);
    add(0, 1, 0, 8'h00, 1,  8'h07, 1, 8'h06, 0);
    run_tbl();

    // Jump, stalled flush, redirect beating a HALT fetch.
    mem[2]    = '{op: 3'b111, rd: 1'b1, rs: 1'b0, imm: 3'd5, addr: 5'd20};
    mem[21]   = '{op: 3'b110, rd: 1'b0, rs: 1'b0, imm: 3'd0, addr: 5'd0};
    mem[8'h41] = '{op: 3'b110, rd: 1'b0, rs: 1'b0, imm: 3'd0, addr: 5'd0};
    add(1, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h01, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h02, 1, 8'h01, 0);
    add(0, 0, 0, 8'h00, 1,  8'h14, 1, 8'h02, 0);
    add(0, 0, 0, 8'h00, 1,  8'h15, 1, 8'h14, 0);
    add(0, 0, 0, 8'h00, 0,  8'h15, 1, 8'h14, 0);
    add(0, 0, 1, 8'h40, 0,  8'h40, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h41, 1, 8'h40, 0);
    add(0, 0, 1, 8'h10, 1,  8'h10, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h11, 1, 8'h10, 0);
    run_tbl();

    // HALT: pc holds, branches ignored, drain, restart from RESET_PC.
    reset_mem();
    mem[3] = '{op: 3'b110, rd: 1'b1, rs: 1'b1, imm: 3'd2, addr: 5'd9};
    add(1, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h01, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h02, 1, 8'h01, 0);
    add(0, 0, 0, 8'h00, 1,  8'h03, 1, 8'h02, 0);
    add(0, 0, 0, 8'h00, 1,  8'h03, 1, 8'h03, 1);
    add(0, 0, 0, 8'h00, 0,  8'h03, 1, 8'h03, 1);
    add(0, 0, 1, 8'h40, 0,  8'h03, 1, 8'h03, 1);
    add(0, 0, 0, 8'h00, 1,  8'h03, 0, 8'h00, 1);
    add(0, 1, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h01, 1, 8'h00, 0);
    run_tbl();

    // PC wrap at 8'hFF, then reset mid-run.
    reset_mem();
    add(1, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h01, 1, 8'h00, 0);
    add(0, 0, 1, 8'hFF, 1,  8'hFF, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h00, 1, 8'hFF, 0);
    add(0, 0, 0, 8'h00, 1,  8'h01, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h02, 1, 8'h01, 0);
    add(1, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    run_tbl();
    check_reset_fields();
    add(0, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  8'h00, 0, 8'h00, 0);
    run_tbl();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
